// File: rtl/sprite_pkg.sv
//==============================================================================
// Module   : sprite_pkg
// Brief    : Shared constants, frame-bit derivation and animation state type
//            for the sprite RAM controller.
// Revision : 1.0
//==============================================================================
`default_nettype none

package sprite_pkg;

  localparam logic [1:0] C_CFG_ORIGIN_X = 2'd0;
  localparam logic [1:0] C_CFG_ORIGIN_Y = 2'd1;
  localparam logic [1:0] C_CFG_CONTROL  = 2'd2;
  localparam logic [1:0] C_CFG_KEY      = 2'd3;

  localparam int C_CTRL_ANIM_EN_BIT = 0;
  localparam int C_CTRL_FSEL_LSB    = 1;
  localparam int C_CTRL_PERIOD_LSB  = 8;
  localparam int C_CTRL_PERIOD_W    = 8;
  localparam int C_KEY_EN_BIT       = 12;

  // Address bits left over for frame select once row/col bits are taken.
  function automatic int frame_bits(input int addr_w, input int spr_log2);
    return addr_w - 2 * spr_log2;
  endfunction

  typedef enum logic [0:0] {
    ST_STATIC = 1'b0,
    ST_ANIM   = 1'b1
  } anim_state_e;

endpackage

`default_nettype wire

// File: rtl/sprite_anim_seq.sv
//==============================================================================
// Module   : sprite_anim_seq
// Brief    : Frame-synchronous sprite animation sequencer (STATIC/ANIM FSM,
//            step counter and displayed frame index).
// Revision : 1.0
//==============================================================================
`default_nettype none

module sprite_anim_seq
  import sprite_pkg::*;
#(
  parameter int FB       = 2,
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                anim_en_next,
  input  logic [FB-1:0]       frame_sel_next,
  input  logic [PERIOD_W-1:0] period_next,
  output logic [FB-1:0]       disp_frame
);

  anim_state_e         state_q, state_d;
  logic [FB-1:0]       disp_q, disp_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_eff;
  logic [PERIOD_W:0]   cnt_inc;

  // The control word becoming the shadow at this frame_start is the one the
  // new frame runs under, so decisions use the *_next values directly.
  always_comb begin
    state_d    = state_q;
    disp_d     = disp_q;
    cnt_d      = cnt_q;
    period_eff = (period_next == '0) ? PERIOD_W'(1) : period_next;
    cnt_inc    = {1'b0, cnt_q} + (PERIOD_W + 1)'(1);
    if (frame_start) begin
      if (!anim_en_next) begin
        state_d = ST_STATIC;
        disp_d  = frame_sel_next;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_STATIC: begin
            state_d = ST_ANIM;
            cnt_d   = '0;
          end
          ST_ANIM: begin
            if (cnt_inc >= {1'b0, period_eff}) begin
              cnt_d  = '0;
              disp_d = disp_q + FB'(1);
            end else begin
              cnt_d = cnt_inc[PERIOD_W-1:0];
            end
          end
          default: state_d = ST_STATIC;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STATIC;
      disp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign disp_frame = disp_q;

endmodule

`default_nettype wire

// File: rtl/sprite_ram_ctrl.sv
//==============================================================================
// Module   : sprite_ram_ctrl
// Brief    : Sprite RAM sequencer: pixel-to-address pipeline with hit/key
//            qualification, tear-free pixel-load gating and config registers.
// Revision : 1.0
//==============================================================================
`default_nettype none

module sprite_ram_ctrl
  import sprite_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int SPR_LOG2   = 5,
  parameter int CNT_WIDTH  = 11,
  parameter int V_ACTIVE   = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_WIDTH-1:0]  x,
  input  logic [CNT_WIDTH-1:0]  y,
  input  logic                  frame_start,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [15:0]           cfg_wdata,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  spr_en,
  output logic                  spr_rgb_unused_guard_n,
  output logic [DATA_WIDTH-1:0] spr_rgb
);

  localparam int FB = frame_bits(ADDR_WIDTH, SPR_LOG2);
  localparam int PW = C_CTRL_PERIOD_W;

  logic [CNT_WIDTH-1:0]  ox_st_q, ox_st_d, oy_st_q, oy_st_d;
  logic [CNT_WIDTH-1:0]  ox_sh_q, ox_sh_d, oy_sh_q, oy_sh_d;
  logic                  anim_en_st_q, anim_en_st_d;
  logic [FB-1:0]         fsel_st_q, fsel_st_d;
  logic [PW-1:0]         period_st_q, period_st_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic                  key_en_q, key_en_d;
  logic [FB-1:0]         disp_frame;

  logic [CNT_WIDTH:0]    dx, dy;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] ram_addr_r_q, ram_addr_r_d;
  logic                  hit_d1_q, hit_d1_d, hit_d2_q, hit_d2_d;
  logic                  ld_fire;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_w_q, ram_addr_w_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;

  // Staging registers; shadows pick up the staged value (including a write
  // landing in the same cycle) on frame_start.
  always_comb begin
    ox_st_d      = ox_st_q;
    oy_st_d      = oy_st_q;
    anim_en_st_d = anim_en_st_q;
    fsel_st_d    = fsel_st_q;
    period_st_d  = period_st_q;
    key_d        = key_q;
    key_en_d     = key_en_q;
    if (cfg_we) begin
      case (cfg_addr)
        C_CFG_ORIGIN_X: ox_st_d = cfg_wdata[CNT_WIDTH-1:0];
        C_CFG_ORIGIN_Y: oy_st_d = cfg_wdata[CNT_WIDTH-1:0];
        C_CFG_CONTROL: begin
          anim_en_st_d = cfg_wdata[C_CTRL_ANIM_EN_BIT];
          fsel_st_d    = cfg_wdata[C_CTRL_FSEL_LSB +: FB];
          period_st_d  = cfg_wdata[C_CTRL_PERIOD_LSB +: PW];
        end
        C_CFG_KEY: begin
          key_d    = cfg_wdata[DATA_WIDTH-1:0];
          key_en_d = cfg_wdata[C_KEY_EN_BIT];
        end
        default: ;
      endcase
    end
    ox_sh_d = frame_start ? ox_st_d : ox_sh_q;
    oy_sh_d = frame_start ? oy_st_d : oy_sh_q;
  end

  sprite_anim_seq #(
    .FB       (FB),
    .PERIOD_W (PW)
  ) u_anim (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .anim_en_next   (anim_en_st_d),
    .frame_sel_next (fsel_st_d),
    .period_next    (period_st_d),
    .disp_frame     (disp_frame)
  );

  // One guard bit above the counter width makes negative offsets fail the
  // range check instead of wrapping into the sprite.
  always_comb begin
    dx           = {1'b0, x} - {1'b0, ox_sh_q};
    dy           = {1'b0, y} - {1'b0, oy_sh_q};
    hit          = (dx[CNT_WIDTH:SPR_LOG2] == '0) && (dy[CNT_WIDTH:SPR_LOG2] == '0);
    ram_addr_r_d = hit ? {disp_frame, dy[SPR_LOG2-1:0], dx[SPR_LOG2-1:0]} : ram_addr_r_q;
    hit_d1_d     = hit;
    hit_d2_d     = hit_d1_q;
  end

  // Loads into the frame on screen are only allowed during vertical blanking.
  assign ld_ready = !reset &&
                    ((y >= CNT_WIDTH'(V_ACTIVE)) || (ld_addr[ADDR_WIDTH-1 -: FB] != disp_frame));
  assign ld_fire  = ld_valid && ld_ready;

  always_comb begin
    ram_we_d     = ld_fire;
    ram_addr_w_d = ld_fire ? ld_addr : ram_addr_w_q;
    ram_din_d    = ld_fire ? ld_data : ram_din_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ox_st_q      <= '0;
      oy_st_q      <= '0;
      ox_sh_q      <= '0;
      oy_sh_q      <= '0;
      anim_en_st_q <= 1'b0;
      fsel_st_q    <= '0;
      period_st_q  <= '0;
      key_q        <= '0;
      key_en_q     <= 1'b0;
      ram_addr_r_q <= '0;
      hit_d1_q     <= 1'b0;
      hit_d2_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_w_q <= '0;
      ram_din_q    <= '0;
    end else begin
      ox_st_q      <= ox_st_d;
      oy_st_q      <= oy_st_d;
      ox_sh_q      <= ox_sh_d;
      oy_sh_q      <= oy_sh_d;
      anim_en_st_q <= anim_en_st_d;
      fsel_st_q    <= fsel_st_d;
      period_st_q  <= period_st_d;
      key_q        <= key_d;
      key_en_q     <= key_en_d;
      ram_addr_r_q <= ram_addr_r_d;
      hit_d1_q     <= hit_d1_d;
      hit_d2_q     <= hit_d2_d;
      ram_we_q     <= ram_we_d;
      ram_addr_w_q <= ram_addr_w_d;
      ram_din_q    <= ram_din_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr_w = ram_addr_w_q;
  assign ram_din    = ram_din_q;
  assign ram_addr_r = ram_addr_r_q;
  assign spr_en     = hit_d2_q && !(key_en_q && (ram_dout == key_q));
  assign spr_rgb    = hit_d2_q ? ram_dout : '0;
  assign spr_rgb_unused_guard_n = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_sprite_ram_ctrl.sv
//==============================================================================
// Module   : tb_sprite_ram_ctrl
// Brief    : Self-checking bench for sprite_ram_ctrl with a behavioural RAM and
//            an integer-level reference model of the sprite layer.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_sprite_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        frame_start, cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        ld_valid, ld_ready;
  logic [11:0] ld_addr, ld_data;
  logic        ram_we;
  logic [11:0] ram_addr_w, ram_din, ram_addr_r;
  logic [11:0] ram_dout;
  logic        spr_en, guard_n;
  logic [11:0] spr_rgb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sprite_ram_ctrl dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ram_we(ram_we), .ram_addr_w(ram_addr_w), .ram_din(ram_din),
    .ram_addr_r(ram_addr_r), .ram_dout(ram_dout),
    .spr_en(spr_en), .spr_rgb_unused_guard_n(guard_n), .spr_rgb(spr_rgb)
  );

  // Physical sprite RAM: registered read, synchronous write, old data on collision.
  logic [11:0] ram_mem [0:4095];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr_w] <= ram_din;
    ram_dout <= ram_mem[ram_addr_r];
  end

  // Reference model state.
  logic [11:0] m_mem [0:4095];
  int          m_oxs, m_oys, m_ox, m_oy;
  logic [15:0] m_ctrl;
  logic [11:0] m_key;
  logic        m_key_en;
  logic        m_anim;
  int          m_cnt, m_disp;
  logic [11:0] m_addr_r;
  logic        m_p1, m_p2;
  logic [11:0] m_p2d;
  logic        m_wpend;
  logic [11:0] m_wa, m_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_oxs = 0; m_oys = 0; m_ox = 0; m_oy = 0; m_ctrl = '0;
    m_key = '0; m_key_en = 1'b0; m_anim = 1'b0; m_cnt = 0; m_disp = 0;
    m_addr_r = '0; m_p1 = 1'b0; m_p2 = 1'b0; m_p2d = '0; m_wpend = 1'b0;
  endtask

  task automatic tick();
    logic        exp_ready, hit;
    logic [11:0] rd;
    int          dx, dy, per;
    @(negedge clk);
    exp_ready = !reset && ((int'(y) >= 480) || (int'(ld_addr) / 1024 != m_disp));
    chk("ld_ready", ld_ready, exp_ready);
    rd = m_mem[m_addr_r];
    if (m_wpend) m_mem[m_wa] = m_wd;
    if (reset) begin
      model_clear();
    end else begin
      dx  = int'(x) - m_ox;
      dy  = int'(y) - m_oy;
      hit = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
      m_p2  = m_p1;
      m_p2d = rd;
      m_p1  = hit;
      if (hit) m_addr_r = 12'(m_disp * 1024 + dy * 32 + dx);
      m_wpend = ld_valid && exp_ready;
      if (m_wpend) begin m_wa = ld_addr; m_wd = ld_data; end
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: m_oxs = int'(cfg_wdata[10:0]);
          2'd1: m_oys = int'(cfg_wdata[10:0]);
          2'd2: m_ctrl = cfg_wdata;
          default: begin m_key = cfg_wdata[11:0]; m_key_en = cfg_wdata[12]; end
        endcase
      end
      if (frame_start) begin
        m_ox = m_oxs;
        m_oy = m_oys;
        if (!m_ctrl[0]) begin
          m_anim = 1'b0; m_disp = int'(m_ctrl[2:1]); m_cnt = 0;
        end else if (!m_anim) begin
          m_anim = 1'b1; m_cnt = 0;
        end else begin
          per = (m_ctrl[15:8] == 8'd0) ? 1 : int'(m_ctrl[15:8]);
          m_cnt++;
          if (m_cnt >= per) begin m_cnt = 0; m_disp = (m_disp + 1) % 4; end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("ram_we", ram_we, m_wpend);
    if (m_wpend) begin
      chk("ram_addr_w", ram_addr_w, m_wa);
      chk("ram_din", ram_din, m_wd);
    end
    chk("ram_addr_r", ram_addr_r, m_addr_r);
    chk("spr_en", spr_en, m_p2 && !(m_key_en && (m_p2d == m_key)));
    chk("spr_rgb", spr_rgb, m_p2 ? m_p2d : 12'h000);
  endtask

  task automatic cfg(input logic [1:0] a, input logic [15:0] d, input logic fs);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; frame_start = fs;
    tick();
    cfg_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    logic [11:0] v;
    for (int i = 0; i < 4096; i++) begin
      v = 12'($urandom_range(0, 7)) * 12'h111;
      ram_mem[i] = v;
      m_mem[i]   = v;
    end
    ram_mem[12'h000] = 12'hF00; m_mem[12'h000] = 12'hF00;
    ram_mem[12'h001] = 12'h000; m_mem[12'h001] = 12'h000;
    model_clear();
    reset = 1'b1; x = '0; y = '0; frame_start = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();
    chk("reset_spr_en", spr_en, 1'b0);
    chk("reset_ld_ready", ld_ready, 1'b0);
    reset = 1'b0;

    // Origin (100,50), static frame 0, hit then miss.
    cfg(2'd0, 16'd100, 1'b0);
    cfg(2'd1, 16'd50, 1'b0);
    cfg(2'd2, 16'h0000, 1'b1);
    x = 11'd100; y = 11'd50; tick();
    chk("hit_addr", ram_addr_r, 12'h000);
    x = 11'd132; tick();
    chk("hit_en", spr_en, 1'b1);
    chk("hit_rgb", spr_rgb, 12'hF00);
    x = 11'd99; tick();
    chk("miss_en", spr_en, 1'b0);
    chk("miss_rgb", spr_rgb, 12'h000);

    // Colour key 0x000 against RAM word 0x001.
    cfg(2'd3, 16'h1000, 1'b0);
    x = 11'd101; tick(); x = 11'd0; tick();
    chk("key_en_on", spr_en, 1'b0);
    chk("key_rgb", spr_rgb, 12'h000);
    x = 11'd101; tick(); x = 11'd0;
    cfg(2'd3, 16'h0000, 1'b0);
    chk("key_off_en", spr_en, 1'b1);

    // Load gating against displayed frame 0.
    y = 11'd200; ld_valid = 1'b1; ld_addr = 12'h010; ld_data = 12'h0AB; tick();
    chk("ld_block", ld_ready, 1'b0);
    ld_addr = 12'h410; #1;
    chk("ld_other_frame", ld_ready, 1'b1);
    tick();
    chk("ld_we", ram_we, 1'b1);
    chk("ld_waddr", ram_addr_w, 12'h410);
    y = 11'd480; ld_addr = 12'h010; ld_data = 12'h0CD; tick();
    chk("ld_blank_we", ram_we, 1'b1);
    ld_valid = 1'b0; y = 11'd50; tick();

    // Animation: period 3, then period 0.
    x = 11'd100;
    cfg(2'd2, 16'h0301, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      pulse(); tick();
      chk("anim_p3_frame", 32'(ram_addr_r[11:10]), 32'((i / 3) % 4));
    end
    cfg(2'd2, 16'h0001, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      pulse(); tick();
      chk("anim_p0_frame", 32'(ram_addr_r[11:10]), 32'(i % 4));
    end

    // Origin staging: mid-frame write is held, coincident write applies at once.
    cfg(2'd2, 16'h0000, 1'b1);
    cfg(2'd0, 16'd110, 1'b0);
    x = 11'd100; tick();
    chk("origin_held", ram_addr_r, 12'h000);
    cfg(2'd0, 16'd120, 1'b1);
    x = 11'd125; tick();
    chk("origin_applied", ram_addr_r, 12'h005);

    // Reset during an accepted load and running animation.
    cfg(2'd2, 16'h0101, 1'b1);
    pulse(); pulse();
    y = 11'd490; ld_valid = 1'b1; ld_addr = 12'hFFF; ld_data = 12'h123; tick();
    reset = 1'b1; ld_valid = 1'b0; tick();
    chk("rst_we", ram_we, 1'b0);
    chk("rst_spr_en", spr_en, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b0);
    reset = 1'b0; y = 11'd100; ld_addr = 12'h000; #1;
    chk("rst_disp_frame0", ld_ready, 1'b0);
    tick();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      frame_start = ($urandom_range(0, 19) == 0);
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_addr    = 2'($urandom_range(0, 3));
      case (cfg_addr)
        2'd0, 2'd1: cfg_wdata = 16'($urandom_range(40, 160));
        2'd2:       cfg_wdata = {8'($urandom_range(0, 3)), 5'($urandom), 3'($urandom)};
        default:    cfg_wdata = {3'($urandom), 1'($urandom), 12'($urandom_range(0, 7)) * 12'h111};
      endcase
      x        = 11'($urandom_range(30, 210));
      y        = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(480, 524))
                                             : 11'($urandom_range(30, 210));
      ld_valid = 1'($urandom);
      ld_addr  = 12'($urandom);
      ld_data  = 12'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_ram_ctrl.md
# sprite_ram_ctrl

Controller that sequences the dual-address sprite RAM (registered read, synchronous write) for the cursor/cat sprite layer. It turns the VGA pixel coordinates into RAM read addresses and produces a hit/transparency-qualified sprite pixel. It also admits external pixel-load writes under a tear-free gating rule and runs a frame-based animation sequencer over multiple sprite frames held in the RAM.

## Interface
- DATA_WIDTH, 12, colour depth of RAM word
- ADDR_WIDTH, 12, RAM address bits
- SPR_LOG2, 5, log2 of sprite side (32x32); frame bits FB = ADDR_WIDTH-2*SPR_LOG2 (=2, 4 frames)
- CNT_WIDTH, 11, pixel counter width
- V_ACTIVE, 480, first blanking line
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- x, y  in  CNT_WIDTH each  current pixel coordinates
- frame_start  in  1  one-cycle pulse at start of each video frame
- cfg_we  in  1  config register write strobe
- cfg_addr  in  2  0 origin_x, 1 origin_y, 2 control, 3 key
- cfg_wdata  in  16  config write data
- ld_valid  in  1  pixel-load request
- ld_ready  out  1  load accepted when ld_valid&&ld_ready
- ld_addr  in  ADDR_WIDTH  target RAM word ({frame, row, col})
- ld_data  in  DATA_WIDTH  pixel value
- ram_we  out  1  to RAM we
- ram_addr_w  out  ADDR_WIDTH  to RAM addr_w
- ram_din  out  DATA_WIDTH  to RAM din
- ram_addr_r  out  ADDR_WIDTH  to RAM addr_r
- ram_dout  in  DATA_WIDTH  from RAM dout (one-cycle registered read)
- spr_en  out  1  sprite pixel opaque and inside sprite
- spr_rgb  out  DATA_WIDTH  sprite colour, 0 when outside sprite

## Operation
- Config regs (staging): origin_x/origin_y = cfg_wdata[CNT_WIDTH-1:0]; control: bit0 anim_en, bits[FB:1] frame_sel, bits[15:8] period; key: bits[11:0] key colour, bit12 key_en. Key takes effect immediately; origin and control copy to shadow regs on frame_start. cfg_we and frame_start in same cycle: shadow loads the newly written value.
- Hit: dx = x-ox, dy = y-oy computed at CNT_WIDTH+1 bits; hit when both in [0, 2**SPR_LOG2). No wrap: negative differences are misses.
- Read address = {disp_frame, dy[SPR_LOG2-1:0], dx[SPR_LOG2-1:0]}; registered. On miss, address holds previous value.
- Animation sequencer (states STATIC, ANIM, selected by shadow anim_en): STATIC — on frame_start disp_frame <= frame_sel, step counter cleared. ANIM — on frame_start counter++; when counter+1 >= max(period,1), counter <= 0, disp_frame <= disp_frame+1 (wraps 2**FB-1 -> 0). STATIC->ANIM keeps current disp_frame.
- Load gating: ld_ready = !reset && (y >= V_ACTIVE || ld_addr[ADDR_WIDTH-1 -: FB] != disp_frame). Accepted load registered into ram_we/ram_addr_w/ram_din for exactly one cycle; back-to-back loads sustain one per cycle.
- Output: spr_en = hit_d2 && !(key_en && ram_dout == key); spr_rgb = hit_d2 ? ram_dout : 0.

## Timing
- Pixel latency 2: x,y at cycle t -> ram_addr_r and hit_d1 at t+1 -> spr_en/spr_rgb valid at t+2.
- Load: accepted at t -> ram_we high at t+1 -> readable by a read issued at t+2. Same-address read and write in one cycle returns old data.
- Reset (any cycle, including mid-load or mid-animation): next cycle ram_we=0, ram_addr_w=0, ram_din=0, ram_addr_r=0, hit pipeline cleared (spr_en=0, spr_rgb=0), all config/shadow regs 0, disp_frame=0, counter=0, STATIC; ld_ready=0 while reset high. An in-flight accepted load is dropped.

## Structure
- Shared package sprite_pkg: cfg address constants, control/key bit positions, FB derivation, anim state enum.
- One sub-module: sprite_anim_seq (shadow control regs, step counter, disp_frame, STATIC/ANIM FSM). Pixel pipeline and load gating stay in top.

## Test plan
- Origin (100,50), STATIC frame 0, RAM[0x000]=0xF00: x=100,y=50 -> ram_addr_r=0x000 at t+1, spr_en=1, spr_rgb=0xF00 at t+2; x=132 -> spr_en=0, spr_rgb=0.
- Key 0x000 enabled, RAM word 0x000 at hit pixel -> spr_en=0, spr_rgb=0x000; key_en=0 -> spr_en=1.
- disp_frame 0, y=200: ld_addr 0x010 -> ld_ready=0; ld_addr 0x410 -> ld_ready=1, ram_we=1 with addr 0x410 next cycle; y=480, ld_addr 0x010 -> accepted.
- period=3, anim_en=1: disp_frame sequence 0,1,2,3,0 advancing every 3rd frame_start; period=0 advances every frame_start.
- Origin write mid-frame leaves ram_addr_r mapping unchanged until frame_start; write coincident with frame_start applies immediately.
- Reset asserted during load and ANIM -> next cycle ram_we=0, spr_en=0, disp_frame=0, ld_ready=0.
